// File: rtl/fsrc_tx_seq_pkg.sv
// Shared types and default sizing for the fractional sample-rate phase sequencer.
package fsrc_tx_seq_pkg;
  localparam int FSRC_WIDTH = 32;
  localparam int FSRC_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;
endpackage

// File: rtl/fsrc_tx_seq_if.sv
// Control/config/result bundle for fsrc_tx_seq; master drives the run, slave is the sequencer.
interface fsrc_tx_seq_if
  import fsrc_tx_seq_pkg::*;
#(
  parameter int WIDTH = FSRC_WIDTH,
  parameter int CNT_W = FSRC_CNT_W
) ();
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] cfg_init;
  logic [WIDTH-1:0] cfg_step;
  logic             cfg_step_wr;
  logic [CNT_W-1:0] cfg_len;
  logic             in_valid;
  logic             out_valid;
  logic             out_hole;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, cfg_init, cfg_step, cfg_step_wr, cfg_len, in_valid,
    input  out_valid, out_hole, busy, done
  );

  modport slave (
    input  start, stop, cfg_init, cfg_step, cfg_step_wr, cfg_len, in_valid,
    output out_valid, out_hole, busy, done
  );
endinterface

// File: rtl/fsrc_tx_seq_accum_set.sv
// Phase accumulator with load; o_wrap is the carry-out of the add happening this cycle.
module accum_set #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_set,
  input  logic [WIDTH-1:0] i_set_val,
  input  logic             i_add,
  input  logic [WIDTH-1:0] i_add_val,
  output logic             o_wrap
);
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH:0]   w_sum;

  assign w_sum  = {1'b0, r_acc} + {1'b0, i_add_val};
  assign o_wrap = i_add & w_sum[WIDTH];

  // Contents are meaningless until the first set, so no reset is needed.
  always_ff @(posedge clk) begin
    if (i_set)      r_acc <= i_set_val;
    else if (i_add) r_acc <= w_sum[WIDTH-1:0];
  end
endmodule

// File: rtl/fsrc_tx_seq.sv
// Run sequencer: IDLE->LOAD->RUN->DRAIN, one accumulate per in_valid, hole = phase wrap.
// Define FSRC_TX_SEQ_STEP_SHADOW_EN to let a shadow step take over at the next wrap during RUN.
module fsrc_tx_seq
  import fsrc_tx_seq_pkg::*;
#(
  parameter int WIDTH = FSRC_WIDTH,
  parameter int CNT_W = FSRC_CNT_W
) (
  input logic          clk,
  input logic          resetn,
  fsrc_tx_seq_if.slave bus
);
  state_e           r_state;
  logic             r_busy, r_done, r_out_valid, r_hole;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_step, r_shadow;
  logic             w_set, w_add, w_wrap, w_last;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_set     = (r_state == LOAD);
  assign w_add     = (r_state == RUN) && bus.in_valid;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // Final sample: its add happens now, its result lands in DRAIN.
  assign w_last    = w_add && (bus.cfg_len != '0) && (w_cnt_inc == bus.cfg_len);

  accum_set #(.WIDTH(WIDTH)) u_acc (
    .clk       (clk),
    .i_set     (w_set),
    .i_set_val (bus.cfg_init),
    .i_add     (w_add),
    .i_add_val (r_step),
    .o_wrap    (w_wrap)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_hole      <= 1'b0;
      r_cnt       <= '0;
      r_step      <= '0;
      r_shadow    <= '0;
    end else begin
      r_out_valid <= w_add;
      r_hole      <= w_wrap;
      if (bus.cfg_step_wr) r_shadow <= bus.cfg_step;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= LOAD;
          r_busy  <= 1'b1;
        end
        LOAD: begin
          r_cnt   <= '0;
          r_step  <= r_shadow;
          r_state <= RUN;
        end
        RUN: begin
          // Saturate so free-run never aliases onto a length match.
          if (bus.in_valid && (r_cnt != '1)) r_cnt <= w_cnt_inc;
`ifdef FSRC_TX_SEQ_STEP_SHADOW_EN
          if (w_wrap) r_step <= r_shadow;
`endif
          if (bus.stop || w_last) begin
            r_state <= DRAIN;
            r_done  <= 1'b1;
          end
        end
        DRAIN: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_hole  = r_hole & r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: doc/fsrc_tx_seq.md
FSRC_TX_SEQ -- requirements
Module: fsrc_tx_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: accumulator and step width in bits.
REQ-002 SHALL have parameter CNT_W, default 16: run-length counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: pulse that begins a run from IDLE.
REQ-006 SHALL have port stop, input, 1: pulse that ends a run early.
REQ-007 SHALL have port cfg_init, input, WIDTH: initial phase loaded at run start.
REQ-008 SHALL have port cfg_step, input, WIDTH: phase increment per sample.
REQ-009 SHALL have port cfg_step_wr, input, 1: pulse that captures cfg_step into the shadow register.
REQ-010 SHALL have port cfg_len, input, CNT_W: samples per run; 0 means free-run.
REQ-011 SHALL have port in_valid, input, 1: sample strobe; one accumulate per strobe.
REQ-012 SHALL have port out_valid, output, 1: per-sample result strobe.
REQ-013 SHALL have port out_hole, output, 1: the accumulate for this sample wrapped; qualified by out_valid.
REQ-014 SHALL have port busy, output, 1: high outside IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse on return to IDLE.

Function
REQ-016 SHALL implement states IDLE, LOAD, RUN, DRAIN.
- IDLE->LOAD on start.
- LOAD->RUN after exactly one cycle.
- RUN->DRAIN when the sample count reaches cfg_len (cfg_len!=0) or on stop.
- DRAIN->IDLE after exactly one cycle, with done=1 in that cycle.
REQ-017 In LOAD the block SHALL drive accumulator set=1 with set_val=cfg_init, clear the sample counter, and copy the shadow step into the active step.
REQ-018 In RUN, each cycle with in_valid=1 SHALL drive add=1 with add_val equal to the active step, and SHALL increment the sample counter.
- in_valid SHALL be ignored in IDLE, LOAD and DRAIN.
REQ-019 out_valid SHALL equal the add strobe delayed one cycle, giving one cycle of latency.
- out_hole SHALL be the accumulator overflow ANDed with out_valid; a held overflow SHALL never be reported twice.
REQ-020 The accumulate SHALL be a WIDTH-bit unsigned sum; the carry-out is the hole, and the sum wraps modulo 2^WIDTH.
REQ-021 The last sample's add SHALL occur in the cycle the counter reaches cfg_len; its out_valid/out_hole SHALL appear in DRAIN.
REQ-022 start SHALL be ignored outside IDLE; stop SHALL be ignored in IDLE and LOAD.
REQ-023 When stop and the final in_valid coincide, that sample SHALL be accumulated and only one done pulse SHALL be produced.
REQ-024 With cfg_len=0, RUN SHALL continue until stop, and the counter SHALL saturate at its maximum.
REQ-025 cfg_step_wr SHALL load the shadow step in any state; the shadow and cfg_step_wr are independent of start.

Reset
REQ-026 On resetn=0:
- state SHALL become IDLE;
- out_valid, out_hole, busy and done SHALL be 0;
- the counter, active step and shadow step SHALL be 0.
REQ-027 Reset asserted mid-run SHALL abort the run without a done pulse.
- The unreset accumulator contents SHALL be don't-care until the next LOAD.

Configuration
REQ-028 Macro FSRC_TX_SEQ_STEP_SHADOW_EN defined:
- a shadow step written during RUN SHALL transfer to the active step in the cycle after an out_hole=1, giving phase-coherent rate change;
- a shadow step written in IDLE SHALL be applied at LOAD.
REQ-029 Macro undefined: the active step SHALL change only in LOAD, and writes during RUN take effect at the next run.

Structure
REQ-030 Package fsrc_tx_seq_pkg SHALL hold the state enum typedef and the default WIDTH/CNT_W constants.
REQ-031 The block SHALL instantiate one accum_set sub-module (WIDTH passed through) and SHALL contain no other arithmetic on the phase.

Verification
REQ-032 The bench SHALL cover these scenarios:
- WIDTH=32, init=0, step=0x4000_0000, len=8, in_valid every cycle -> 8 out_valid, out_hole on samples 4 and 8, one done pulse, busy low afterwards.
- len=0, step=0x8000_0000, in_valid every other cycle, stop after 5 samples -> holes on samples 2 and 4, done in the cycle after DRAIN entry.
- Macro defined, step=0x4000_0000, shadow write 0x8000_0000 after sample 2 -> holes on samples 4, 6, 8.
- Macro undefined, same stimulus -> holes on samples 4 and 8 only; the next run uses 0x8000_0000.
- stop coincident with sample 3 of len=3 -> 3 out_valid, exactly one done.
- resetn pulled low in RUN, then start -> no done for the aborted run; the new run starts from cfg_init with no stale out_hole.
